// File: rtl/scope_acq_if.sv
// Sample-path and RAM-write signals shared by the acquisition controller and its neighbours.
// Strobe semantics: sample_valid is a one-cycle qualifier with no ready; sample is consumed
// (or dropped by decimation/state) in the cycle it is high, and wr_en is a one-cycle write strobe.
interface scope_acq_if #(
    parameter int ADDR_W = 9
);
    logic              sample_valid;
    logic [7:0]        sample;
    logic [7:0]        level;
    logic              slope;
    logic              mode;
    logic [1:0]        time_per_div;
    logic              vblank;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              buf_sel;
    logic [ADDR_W-1:0] disp_start;
    logic              frame_ready;
    logic              armed;

    modport master (
        output sample_valid, sample, level, slope, mode, time_per_div, vblank,
        input  wr_en, wr_bank, wr_addr, wr_data, buf_sel, disp_start, frame_ready, armed
    );

    modport slave (
        input  sample_valid, sample, level, slope, mode, time_per_div, vblank,
        output wr_en, wr_bank, wr_addr, wr_data, buf_sel, disp_start, frame_ready, armed
    );
endinterface

// File: rtl/scope_acq_controller.sv
// Oscilloscope acquisition sequencer: decimation, pre-trigger ring, level/slope/auto trigger,
// and double-buffered sample RAM bank swap at vertical-blank start.
module scope_acq_controller #(
    parameter int ADDR_W       = 9,
    parameter int PRE_TRIG     = 64,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    scope_acq_if.slave bus,
    output logic [2:0] dbg_state
);
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_TRIG;
    localparam int CNT_W    = $clog2(AUTO_TIMEOUT + DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRETRIG = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        tdiv_lat;
    logic [5:0]        decim_cnt;
    logic [5:0]        decim_mask;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] trig_addr;
    logic [CNT_W-1:0]  seq_cnt;
    logic [7:0]        prev_sample;
    logic              prev_valid;
    logic              vblank_q;

    logic active;
    logic accept;
    logic level_hit;
    logic auto_hit;
    logic trig_hit;
    logic vblank_rise;
    logic start_acq;
    logic swap;

    // Ratio 1/4/16/64 realised as a counter wrapped by a power-of-two mask.
    always_comb begin
        case (tdiv_lat)
            2'd0:    decim_mask = 6'd0;
            2'd1:    decim_mask = 6'd3;
            2'd2:    decim_mask = 6'd15;
            default: decim_mask = 6'd63;
        endcase
    end

    assign active      = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST);
    assign accept      = active && bus.sample_valid && (decim_cnt == 6'd0);
    assign level_hit   = prev_valid &&
                         (bus.slope ? ((prev_sample >= bus.level) && (bus.sample <  bus.level))
                                    : ((prev_sample <  bus.level) && (bus.sample >= bus.level)));
    // seq_cnt holds the number of earlier ARMED samples, so this fires on the AUTO_TIMEOUT-th.
    assign auto_hit    = !bus.mode && (seq_cnt >= CNT_W'(AUTO_TIMEOUT - 1));
    assign trig_hit    = (state == S_ARMED) && accept && (level_hit || auto_hit);
    assign vblank_rise = bus.vblank && !vblank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acq = 1'b0;
        swap      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_PRETRIG;
                start_acq = 1'b1;
            end
            S_PRETRIG: begin
                if (accept && (seq_cnt == CNT_W'(PRE_TRIG - 1))) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (trig_hit) state_nxt = S_POST;
            end
            S_POST: begin
                if (accept && (seq_cnt == CNT_W'(POST_LEN - 1))) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (vblank_rise) begin
                    state_nxt = S_PRETRIG;
                    start_acq = 1'b1;
                    swap      = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.buf_sel     <= 1'b0;
            bus.disp_start  <= '0;
            bus.frame_ready <= 1'b0;
            bus.armed       <= 1'b0;
            tdiv_lat        <= 2'd0;
            decim_cnt       <= 6'd0;
            wptr            <= '0;
            trig_addr       <= '0;
            seq_cnt         <= '0;
            prev_sample     <= 8'd0;
            prev_valid      <= 1'b0;
            vblank_q        <= 1'b0;
        end else begin
            vblank_q        <= bus.vblank;
            bus.wr_en       <= accept;
            bus.frame_ready <= swap;
            bus.armed       <= (state == S_ARMED);

            if (accept) begin
                bus.wr_addr <= wptr;
                bus.wr_data <= bus.sample;
                wptr        <= wptr + ADDR_W'(1);
                prev_sample <= bus.sample;
                prev_valid  <= 1'b1;
            end

            if (active && bus.sample_valid) decim_cnt <= (decim_cnt + 6'd1) & decim_mask;

            // seq_cnt is reused: pre-trigger writes, ARMED timeout, then post-trigger writes.
            case (state)
                S_PRETRIG: begin
                    if (accept) seq_cnt <= (state_nxt == S_ARMED) ? '0 : seq_cnt + CNT_W'(1);
                end
                S_ARMED: begin
                    if (trig_hit) begin
                        seq_cnt   <= CNT_W'(1);
                        trig_addr <= wptr;
                    end else if (accept && (seq_cnt < CNT_W'(AUTO_TIMEOUT - 1))) begin
                        seq_cnt <= seq_cnt + CNT_W'(1);
                    end
                end
                S_POST: begin
                    if (accept) seq_cnt <= seq_cnt + CNT_W'(1);
                end
                default: ;
            endcase

            if (swap) begin
                bus.buf_sel    <= ~bus.buf_sel;
                bus.disp_start <= trig_addr - ADDR_W'(PRE_TRIG);
            end

            if (start_acq) begin
                tdiv_lat   <= bus.time_per_div;
                decim_cnt  <= 6'd0;
                wptr       <= '0;
                seq_cnt    <= '0;
                prev_valid <= 1'b0;
            end
        end
    end

    assign bus.wr_bank = ~bus.buf_sel;
    assign dbg_state   = state;
endmodule

// File: tb/tb_scope_acq_controller.sv
// Self-checking bench for scope_acq_controller: decimation table, directed acquisition
// scenarios and randomized runs against an acquisition-level reference model.
module tb_scope_acq_controller;
    localparam int ADDR_W       = 9;
    localparam int DEPTH        = 512;
    localparam int PRE_TRIG     = 64;
    localparam int AUTO_TIMEOUT = 1024;
    localparam int POST_LEN     = DEPTH - PRE_TRIG;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    scope_acq_if #(.ADDR_W(ADDR_W)) bus ();

    scope_acq_controller #(
        .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one acquisition is the list of accepted samples plus the trigger index.
    int m_idle;
    int acc[$];
    int trig_idx;
    int strobe_cnt;
    int ratio;
    int m_buf_sel;
    int m_disp;
    int m_vb_prev;

    int   wr_seen;
    int   last_addr;
    int   fr_seen;
    logic cur_vb;

    typedef struct {
        int tdiv;
        int nstrobes;
        int exp_writes;
    } dec_vec_t;

    dec_vec_t dec_tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // 0 idle, 1 pre-trigger, 2 armed, 3 post-trigger, 4 done
    function automatic int m_phase();
        if (m_idle != 0) return 0;
        if (acc.size() < PRE_TRIG) return 1;
        if (trig_idx < 0) return 2;
        if (acc.size() - trig_idx < POST_LEN) return 3;
        return 4;
    endfunction

    task automatic m_start();
        m_idle     = 0;
        acc.delete();
        trig_idx   = -1;
        strobe_cnt = 0;
        ratio      = 1 << (2 * int'(bus.time_per_div));
    endtask

    task automatic cycle(input logic v, input logic [7:0] s, input logic vb, input logic r);
        int ph;
        int e_wr, e_addr, e_data, e_fr, e_armed;
        int lvl, prv;
        ph     = m_phase();
        e_wr   = 0;
        e_addr = 0;
        e_data = 0;
        e_fr   = 0;
        e_armed = (!r && ph == 2) ? 1 : 0;
        bus.sample_valid = v;
        bus.sample       = s;
        bus.vblank       = vb;
        rst              = r;
        if (r) begin
            m_idle    = 1;
            acc.delete();
            trig_idx  = -1;
            m_buf_sel = 0;
            m_disp    = 0;
            m_vb_prev = 0;
        end else begin
            if (ph == 0) begin
                m_start();
            end else if (ph == 4) begin
                if (vb && !m_vb_prev[0]) begin
                    m_buf_sel = 1 - m_buf_sel;
                    m_disp    = ((trig_idx % DEPTH) - PRE_TRIG + DEPTH) % DEPTH;
                    e_fr      = 1;
                    m_start();
                end
            end else if (v) begin
                if (strobe_cnt % ratio == 0) begin
                    e_wr   = 1;
                    e_addr = acc.size() % DEPTH;
                    e_data = int'(s);
                    if (ph == 2) begin
                        lvl = int'(bus.level);
                        prv = acc[$];
                        if (bus.slope ? (prv >= lvl && int'(s) < lvl) : (prv < lvl && int'(s) >= lvl))
                            trig_idx = acc.size();
                        else if (!bus.mode && (acc.size() - PRE_TRIG + 1) >= AUTO_TIMEOUT)
                            trig_idx = acc.size();
                    end
                    acc.push_back(int'(s));
                end
                strobe_cnt++;
            end
            m_vb_prev = int'(vb);
        end
        @(posedge clk);
        #1;
        chk("wr_en", int'(bus.wr_en), e_wr);
        if (e_wr != 0) begin
            chk("wr_addr", int'(bus.wr_addr), e_addr);
            chk("wr_data", int'(bus.wr_data), e_data);
            chk("wr_bank", int'(bus.wr_bank), 1 - m_buf_sel);
        end
        if (r) begin
            chk("rst_wr_addr", int'(bus.wr_addr), 0);
            chk("rst_wr_data", int'(bus.wr_data), 0);
        end
        chk("buf_sel", int'(bus.buf_sel), m_buf_sel);
        chk("disp_start", int'(bus.disp_start), m_disp);
        chk("frame_ready", int'(bus.frame_ready), e_fr);
        chk("armed", int'(bus.armed), e_armed);
        if (bus.wr_en) begin
            wr_seen++;
            last_addr = int'(bus.wr_addr);
        end
        if (bus.frame_ready) fr_seen++;
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // kind: 0 ramp, 1 600x200 then 50, 2 constant 100, 3 random with occasional level changes
    task automatic feed(input int kind, input int max_strobes, input int gap_max);
        int k;
        logic [7:0] s;
        k = 0;
        while (m_phase() != 4 && k < max_strobes) begin
            case (kind)
                0:       s = 8'(k);
                1:       s = (k < 600) ? 8'd200 : 8'd50;
                2:       s = 8'd100;
                default: begin
                    s = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 49) == 0) bus.level = 8'($urandom_range(0, 255));
                end
            endcase
            cycle(1'b1, s, cur_vb, 1'b0);
            repeat ($urandom_range(0, gap_max)) cycle(1'b0, 8'h00, cur_vb, 1'b0);
            k++;
        end
    endtask

    task automatic expect_done(input string name);
        checks++;
        if (m_phase() != 4) begin
            errors++;
            $display("FAIL %s acquisition did not complete within its strobe budget", name);
        end
    endtask

    task automatic vblank_pulse();
        fr_seen = 0;
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic set_ctrl(input int lvl, input int slp, input int md, input int td);
        bus.level        = 8'(lvl);
        bus.slope        = slp[0];
        bus.mode         = md[0];
        bus.time_per_div = 2'(td);
    endtask

    initial begin
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample       = 8'h00;
        bus.vblank       = 1'b0;
        cur_vb           = 1'b0;
        set_ctrl(128, 0, 1, 0);
        m_idle = 1; trig_idx = -1; strobe_cnt = 0; ratio = 1;
        m_buf_sel = 0; m_disp = 0; m_vb_prev = 0;
        wr_seen = 0; last_addr = 0; fr_seen = 0;

        dec_tbl[0] = '{0, 10, 10};
        dec_tbl[1] = '{1, 10, 3};
        dec_tbl[2] = '{2, 33, 3};
        dec_tbl[3] = '{3, 65, 2};
        dec_tbl[4] = '{2, 16, 1};
        dec_tbl[5] = '{1, 4, 1};
        dec_tbl[6] = '{3, 1, 1};

        do_reset(2);

        // Decimation table: writes produced by n strobes at each ratio
        for (int i = 0; i < 7; i++) begin
            set_ctrl(128, 0, 1, dec_tbl[i].tdiv);
            do_reset(2);
            wr_seen = 0;
            for (int j = 0; j < dec_tbl[i].nstrobes; j++) begin
                cycle(1'b1, 8'($urandom_range(0, 100)), 1'b0, 1'b0);
                if ($urandom_range(0, 1) == 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            end
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("tbl_writes", wr_seen, dec_tbl[i].exp_writes);
        end

        // Rising-edge trigger on a ramp
        set_ctrl(128, 0, 1, 0);
        do_reset(2);
        wr_seen = 0;
        feed(0, 2000, 1);
        expect_done("t2");
        chk("t2_total_writes", wr_seen, 576);
        chk("t2_last_addr", last_addr, 63);
        vblank_pulse();
        chk("t2_buf_sel", int'(bus.buf_sel), 1);
        chk("t2_disp_start", int'(bus.disp_start), 64);
        chk("t2_frame_pulses", fr_seen, 1);

        // Falling-edge trigger on a step
        set_ctrl(128, 1, 1, 0);
        do_reset(2);
        feed(1, 2000, 1);
        expect_done("t3");
        vblank_pulse();
        chk("t3_disp_start", int'(bus.disp_start), 24);

        // Auto mode forces a trigger; normal mode waits forever
        set_ctrl(128, 0, 0, 0);
        do_reset(2);
        feed(2, 3000, 0);
        expect_done("t4");
        vblank_pulse();
        chk("t4_disp_start", int'(bus.disp_start), 511);
        chk("t4_frame_pulses", fr_seen, 1);
        set_ctrl(128, 0, 1, 0);
        do_reset(2);
        fr_seen = 0;
        for (int k = 0; k < 5000; k++) cycle(1'b1, 8'd100, (k % 500) < 3, 1'b0);
        chk("t4_normal_no_frame", fr_seen, 0);
        chk("t4_normal_armed", int'(bus.armed), 1);

        // Decimation ratio latched per acquisition
        set_ctrl(128, 0, 0, 2);
        do_reset(2);
        wr_seen = 0;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            if (k == 0) chk("t5_first_strobe_writes", wr_seen, 1);
        end
        chk("t5_ratio16", wr_seen, 2);
        bus.time_per_div = 2'd0;
        wr_seen = 0;
        for (int k = 0; k < 64; k++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("t5_ratio_held", wr_seen, 4);
        feed(3, 10000, 0);
        expect_done("t5");
        vblank_pulse();
        wr_seen = 0;
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("t5_ratio1_after_swap", wr_seen, 4);

        // DONE entered with vblank already high
        set_ctrl(128, 0, 1, 0);
        do_reset(2);
        cur_vb = 1'b0;
        feed(0, 200, 0);
        cur_vb = 1'b1;
        feed(0, 2000, 0);
        expect_done("t6");
        wr_seen = 0;
        fr_seen = 0;
        repeat (20) cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("t6_no_write_in_done", wr_seen, 0);
        chk("t6_no_swap_while_high", fr_seen, 0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_swap_on_new_rise", fr_seen, 1);
        chk("t6_buf_sel", int'(bus.buf_sel), 1);
        cur_vb = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of an acquisition
        feed(0, 100, 0);
        do_reset(2);
        chk("t1_buf_sel", int'(bus.buf_sel), 0);
        wr_seen = 0;
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("t1_first_write", wr_seen, 1);
        chk("t1_first_addr", last_addr, 0);

        // Randomized acquisitions
        do_reset(2);
        for (int a = 0; a < 4; a++) begin
            set_ctrl($urandom_range(40, 215), $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1));
            feed(3, 6000, 2);
            expect_done("rand");
            vblank_pulse();
            chk("rand_frame_pulses", fr_seen, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
